// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// This block starts the CPU interrupt handshake. It detects rising edges on
// int_pin and raises `interrupt` to the control unit. The request stays high
// until the control unit acknowledges with interrupt_save. The block then
// tracks the in-service state until RTI (restore_flags). It also keeps a
// shadow copy of the Z/N/C/V flags, captured on save_flags.
//
// Optional build macro: INT_SYNC_EN
//   defined   : int_pin passes through a SYNC_STAGES flip-flop synchronizer
//               (reset to 1) before edge detect. Request latency is
//               SYNC_STAGES+1 cycles.
//   undefined : int_pin is treated as synchronous to clk. Request latency is
//               1 cycle.
//
// Parameters:
//   ACK_TIMEOUT  number of REQ cycles without an ack before ack_timeout sets
//                (1..255)
//   SYNC_STAGES  synchronizer depth, used only with INT_SYNC_EN (>= 2)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   int_pin        in   external interrupt line, rising-edge triggered
//   int_en         in   global enable; 0 blocks new requests (pending kept)
//   interrupt_save in   control unit ack, context save in progress
//   save_flags     in   capture {z,n,c,v} into the shadow register
//   restore_flags  in   RTI executing, ends service
//   z/n/c/v_flag   in   current flags from the flags register
//   status_clr     in   clears the sticky status bits
//   interrupt      out  request to the control unit
//   in_service     out  handler running
//   saved_flags    out  shadow {z,n,c,v}
//   int_lost       out  sticky: an edge was merged or dropped
//   ack_timeout    out  sticky: request left unacknowledged for ACK_TIMEOUT cycles
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int ACK_TIMEOUT = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_pin,
  input  logic       int_en,
  input  logic       interrupt_save,
  input  logic       save_flags,
  input  logic       restore_flags,
  input  logic       z_flag,
  input  logic       n_flag,
  input  logic       c_flag,
  input  logic       v_flag,
  input  logic       status_clr,
  output logic       interrupt,
  output logic       in_service,
  output logic [3:0] saved_flags,
  output logic       int_lost,
  output logic       ack_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(ACK_TIMEOUT);

  state_t     r_state;
  state_t     w_state_next;
  logic       w_pin_s;
  logic       r_pin_prev;
  logic       w_edge;
  logic       r_pending;
  logic       w_pending_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic       w_cnt_hit;
  logic       w_lost_set;
  logic       w_to_set;
  logic       r_int_lost;
  logic       r_ack_timeout;
  logic [3:0] r_saved_flags;

`ifdef INT_SYNC_EN
  // The synchronizer resets to 1. A pin that is already high when reset is
  // released therefore looks like a steady level, not a new edge.
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], int_pin};
    end
  end

  assign w_pin_s = r_sync[SYNC_STAGES-1];
`else
  assign w_pin_s = int_pin;
`endif

  assign w_edge = w_pin_s & ~r_pin_prev;

  // This cycle's no-ack REQ cycle is the one that brings the count to the
  // limit. The count saturates, so the comparison stays true once reached.
  assign w_cnt_hit = (r_cnt >= (TIMEOUT_VAL - 8'd1));

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_cnt_next     = r_cnt;
    w_lost_set     = 1'b0;
    w_to_set       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (int_en && (w_edge || r_pending)) begin
          // A fresh edge is consumed directly. A latched pending request is
          // consumed as well. If both arrive together they become one request.
          w_state_next   = ST_REQ;
          w_pending_next = 1'b0;
          w_cnt_next     = 8'd0;
          w_lost_set     = w_edge & r_pending;
        end else if (w_edge) begin
          w_pending_next = 1'b1;
          w_lost_set     = r_pending;
        end
      end

      ST_REQ: begin
        // An edge during REQ is folded into the request already outstanding.
        w_lost_set = w_edge;
        if (interrupt_save) begin
          w_state_next = ST_SERVICE;
          w_cnt_next   = 8'd0;
        end else if (w_cnt_hit) begin
          w_cnt_next = TIMEOUT_VAL;
          w_to_set   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end

      ST_SERVICE: begin
        if (w_edge) begin
          w_pending_next = 1'b1;
          w_lost_set     = r_pending;
        end
        if (restore_flags) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pin_prev    <= 1'b1;
      r_pending     <= 1'b0;
      r_cnt         <= 8'd0;
      r_int_lost    <= 1'b0;
      r_ack_timeout <= 1'b0;
      r_saved_flags <= 4'b0000;
    end else begin
      r_state       <= w_state_next;
      r_pin_prev    <= w_pin_s;
      r_pending     <= w_pending_next;
      r_cnt         <= w_cnt_next;
      // A set event takes priority over a clear in the same cycle.
      r_int_lost    <= w_lost_set | (r_int_lost & ~status_clr);
      r_ack_timeout <= w_to_set | (r_ack_timeout & ~status_clr);
      if (save_flags) begin
        r_saved_flags <= {z_flag, n_flag, c_flag, v_flag};
      end
    end
  end

  assign interrupt   = (r_state == ST_REQ);
  assign in_service  = (r_state == ST_SERVICE);
  assign saved_flags = r_saved_flags;
  assign int_lost    = r_int_lost;
  assign ack_timeout = r_ack_timeout;

endmodule
